// File: rtl/grf_wb_arb_pkg.sv
// Shared types and constants for the register-file write-back arbiter.
// Holds address/data widths, the zero register and the write request bundle.
package grf_wb_arb_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam int NUM_REGS   = 1 << REG_ADDR_W;

    localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rw;
        logic [DATA_W-1:0]     data;
    } wr_req_t;

    // One-hot decode of a register address; $0 never reports.
    function automatic logic [NUM_REGS-1:0] reg_onehot(
        input logic [REG_ADDR_W-1:0] rw
    );
        logic [NUM_REGS-1:0] v;
        v     = '0;
        v[rw] = 1'b1;
        v[0]  = 1'b0;
        return v;
    endfunction

endpackage

// File: rtl/grf_wb_fifo.sv
// MDU result buffer: in-order FIFO with occupancy and per-slot valid bits.
// Ports: clk/reset, push+push_req, pop, head, empty/full/empty_next,
// entry_vld and flattened entry_rw for pending-register decode.
module grf_wb_fifo
    import grf_wb_arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        push,
    input  wr_req_t                     push_req,
    input  logic                        pop,
    output wr_req_t                     head,
    output logic                        empty,
    output logic                        full,
    output logic                        empty_next,
    output logic [DEPTH-1:0]            entry_vld,
    output logic [DEPTH*REG_ADDR_W-1:0] entry_rw
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DEPTH-1:0] vld_q, vld_d;
    wr_req_t          mem_q [DEPTH];
    wr_req_t          mem_d [DEPTH];

    // Push only when not full and pop only when not empty, so a
    // simultaneous push/pop never touches the same slot.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        vld_d    = vld_q;
        mem_d    = mem_q;
        cnt_d    = cnt_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_req;
            vld_d[wr_ptr_q] = 1'b1;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            vld_d[rd_ptr_q] = 1'b0;
            rd_ptr_d        = rd_ptr_q + 1'b1;
        end
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            vld_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            vld_q    <= vld_d;
            mem_q    <= mem_d;
        end
    end

    always_comb begin
        entry_rw = '0;
        for (int i = 0; i < DEPTH; i++) begin
            entry_rw[i*REG_ADDR_W +: REG_ADDR_W] = mem_q[i].rw;
        end
    end

    assign head       = mem_q[rd_ptr_q];
    assign empty      = (cnt_q == '0);
    assign full       = (cnt_q == CNT_W'(DEPTH));
    assign empty_next = (cnt_d == '0);
    assign entry_vld  = vld_q;

endmodule

// File: rtl/grf_wb_arb.sv
// Register-file write-back arbiter: W-stage writes win, buffered MDU
// results fill idle slots; starvation raises stall_req to drain the buffer.
// Ports: clk/reset, wb_* (pipeline), mdu_* (MDU, valid/ready),
// RegWrite/RW/DataW (registered RF write), pending, stall_req.
module grf_wb_arb
    import grf_wb_arb_pkg::*;
#(
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wb_valid,
    input  logic [REG_ADDR_W-1:0] wb_rw,
    input  logic [DATA_W-1:0]     wb_data,
    input  logic                  mdu_valid,
    input  logic [REG_ADDR_W-1:0] mdu_rw,
    input  logic [DATA_W-1:0]     mdu_data,
    output logic                  mdu_ready,
    output logic                  RegWrite,
    output logic [REG_ADDR_W-1:0] RW,
    output logic [DATA_W-1:0]     DataW,
    output logic [NUM_REGS-1:0]   pending,
    output logic                  stall_req
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIM = SW'(STARVE_LIMIT);

    logic wb_hit, pop, push;
    logic fifo_empty, fifo_full, fifo_empty_next;
    wr_req_t head, push_req;
    logic [FIFO_DEPTH-1:0]            entry_vld;
    logic [FIFO_DEPTH*REG_ADDR_W-1:0] entry_rw;

    logic                  regwrite_q, regwrite_d;
    logic [REG_ADDR_W-1:0] rw_q, rw_d;
    logic [DATA_W-1:0]     dataw_q, dataw_d;
    logic [SW-1:0]         starve_q, starve_d;
    logic                  stall_q, stall_d;

    // Writes to $0 are dropped and never occupy a slot.
    assign wb_hit    = wb_valid && (wb_rw != ZERO_REG);
    assign pop       = !fifo_empty && !wb_hit;
    assign mdu_ready = !fifo_full;
    assign push      = mdu_valid && mdu_ready
                    && (mdu_rw != ZERO_REG);
    assign push_req  = '{rw: mdu_rw, data: mdu_data};

    grf_wb_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .push_req   (push_req),
        .pop        (pop),
        .head       (head),
        .empty      (fifo_empty),
        .full       (fifo_full),
        .empty_next (fifo_empty_next),
        .entry_vld  (entry_vld),
        .entry_rw   (entry_rw)
    );

    always_comb begin
        regwrite_d = 1'b0;
        rw_d       = ZERO_REG;
        dataw_d    = '0;
        unique case (1'b1)
            wb_hit: begin
                regwrite_d = 1'b1;
                rw_d       = wb_rw;
                dataw_d    = wb_data;
            end
            pop: begin
                regwrite_d = 1'b1;
                rw_d       = head.rw;
                dataw_d    = head.data;
            end
            default: ;
        endcase
    end

    // Counter only runs while results wait behind wb writes; once it
    // saturates, stall_req latches until the buffer drains.
    always_comb begin
        starve_d = starve_q;
        if (fifo_empty || pop) begin
            starve_d = '0;
        end else if (starve_q != LIM) begin
            starve_d = starve_q + 1'b1;
        end
        stall_d = (stall_q || (starve_q == LIM))
               && !fifo_empty_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regwrite_q <= 1'b0;
            rw_q       <= ZERO_REG;
            dataw_q    <= '0;
            starve_q   <= '0;
            stall_q    <= 1'b0;
        end else begin
            regwrite_q <= regwrite_d;
            rw_q       <= rw_d;
            dataw_q    <= dataw_d;
            starve_q   <= starve_d;
            stall_q    <= stall_d;
        end
    end

    always_comb begin
        pending = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (entry_vld[i]) begin
                pending = pending | reg_onehot(
                    entry_rw[i*REG_ADDR_W +: REG_ADDR_W]);
            end
        end
    end

    assign RegWrite  = regwrite_q;
    assign RW        = rw_q;
    assign DataW     = dataw_q;
    assign stall_req = stall_q;

endmodule

// File: tb/tb_grf_wb_arb.sv
// Directed bench for grf_wb_arb: vector table plus async reset sequence.
// Each row drives one cycle; outputs are compared just after the edge.
module tb_grf_wb_arb;

    logic        clk;
    logic        reset;
    logic        wb_valid;
    logic [4:0]  wb_rw;
    logic [31:0] wb_data;
    logic        mdu_valid;
    logic [4:0]  mdu_rw;
    logic [31:0] mdu_data;
    logic        mdu_ready;
    logic        RegWrite;
    logic [4:0]  RW;
    logic [31:0] DataW;
    logic [31:0] pending;
    logic        stall_req;

    int n_chk;
    int n_fail;

    grf_wb_arb #(
        .FIFO_DEPTH   (2),
        .STARVE_LIMIT (3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .wb_valid  (wb_valid),
        .wb_rw     (wb_rw),
        .wb_data   (wb_data),
        .mdu_valid (mdu_valid),
        .mdu_rw    (mdu_rw),
        .mdu_data  (mdu_data),
        .mdu_ready (mdu_ready),
        .RegWrite  (RegWrite),
        .RW        (RW),
        .DataW     (DataW),
        .pending   (pending),
        .stall_req (stall_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wv;
        logic [4:0]  wrw;
        logic [31:0] wd;
        logic        mv;
        logic [4:0]  mrw;
        logic [31:0] md;
        logic        ewe;
        logic [4:0]  erw;
        logic [31:0] ed;
        logic [31:0] ep;
        logic        er;
        logic        es;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(
        input logic wv, input logic [4:0] wrw,
        input logic [31:0] wd,
        input logic mv, input logic [4:0] mrw,
        input logic [31:0] md,
        input logic ewe, input logic [4:0] erw,
        input logic [31:0] ed, input logic [31:0] ep,
        input logic er, input logic es
    );
        vec_t v;
        v.wv = wv;  v.wrw = wrw; v.wd = wd;
        v.mv = mv;  v.mrw = mrw; v.md = md;
        v.ewe = ewe; v.erw = erw; v.ed = ed;
        v.ep = ep;  v.er = er;   v.es = es;
        return v;
    endfunction

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h",
                     nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic wv, input logic [4:0] wrw,
                         input logic [31:0] wd,
                         input logic mv, input logic [4:0] mrw,
                         input logic [31:0] md);
        wb_valid  = wv;
        wb_rw     = wrw;
        wb_data   = wd;
        mdu_valid = mv;
        mdu_rw    = mrw;
        mdu_data  = md;
    endtask

    task automatic chk_idle_out(input string nm);
        chk({nm, ".RegWrite"}, 32'(RegWrite), 32'd0);
        chk({nm, ".RW"}, 32'(RW), 32'd0);
        chk({nm, ".DataW"}, DataW, 32'd0);
        chk({nm, ".pending"}, pending, 32'd0);
        chk({nm, ".mdu_ready"}, 32'(mdu_ready), 32'd1);
        chk({nm, ".stall_req"}, 32'(stall_req), 32'd0);
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        reset  = 1'b1;
        drive(0, 0, 0, 0, 0, 0);

        // wv wrw wd | mv mrw md | we rw d | pend rdy stall
        tv.push_back(mk(1, 8, 32'h1234, 0, 0, 0,
                        1, 8, 32'h1234, 0, 1, 0));
        tv.push_back(mk(0, 0, 0, 1, 2, 32'hA5A5,
                        0, 0, 0, 32'h4, 1, 0));
        tv.push_back(mk(0, 0, 0, 0, 0, 0,
                        1, 2, 32'hA5A5, 0, 1, 0));
        tv.push_back(mk(0, 0, 0, 1, 0, 32'h77,
                        0, 0, 0, 0, 1, 0));
        tv.push_back(mk(0, 0, 0, 0, 0, 0,
                        0, 0, 0, 0, 1, 0));
        tv.push_back(mk(0, 0, 0, 1, 5, 32'h55,
                        0, 0, 0, 32'h20, 1, 0));
        tv.push_back(mk(1, 0, 32'hDEAD, 0, 0, 0,
                        1, 5, 32'h55, 0, 1, 0));
        tv.push_back(mk(0, 0, 0, 0, 0, 0,
                        0, 0, 0, 0, 1, 0));
        tv.push_back(mk(1, 9, 32'h99, 1, 3, 32'h33,
                        1, 9, 32'h99, 32'h8, 1, 0));
        tv.push_back(mk(1, 9, 32'h99, 1, 4, 32'h44,
                        1, 9, 32'h99, 32'h18, 0, 0));
        tv.push_back(mk(1, 9, 32'h99, 1, 6, 32'h66,
                        1, 9, 32'h99, 32'h18, 0, 0));
        tv.push_back(mk(1, 9, 32'h99, 0, 0, 0,
                        1, 9, 32'h99, 32'h18, 0, 0));
        tv.push_back(mk(1, 9, 32'h99, 0, 0, 0,
                        1, 9, 32'h99, 32'h18, 0, 1));
        tv.push_back(mk(1, 10, 32'h1010, 0, 0, 0,
                        1, 10, 32'h1010, 32'h18, 0, 1));
        tv.push_back(mk(0, 0, 0, 0, 0, 0,
                        1, 3, 32'h33, 32'h10, 1, 1));
        tv.push_back(mk(0, 0, 0, 0, 0, 0,
                        1, 4, 32'h44, 0, 1, 0));
        tv.push_back(mk(0, 0, 0, 0, 0, 0,
                        0, 0, 0, 0, 1, 0));
        tv.push_back(mk(0, 0, 0, 1, 7, 32'h70,
                        0, 0, 0, 32'h80, 1, 0));
        tv.push_back(mk(0, 0, 0, 1, 11, 32'hB0,
                        1, 7, 32'h70, 32'h800, 1, 0));
        tv.push_back(mk(0, 0, 0, 0, 0, 0,
                        1, 11, 32'hB0, 0, 1, 0));

        tick();
        tick();
        chk_idle_out("rst");
        reset = 1'b0;

        for (int i = 0; i < tv.size(); i++) begin
            drive(tv[i].wv, tv[i].wrw, tv[i].wd,
                  tv[i].mv, tv[i].mrw, tv[i].md);
            tick();
            chk($sformatf("v%0d.RegWrite", i),
                32'(RegWrite), 32'(tv[i].ewe));
            chk($sformatf("v%0d.RW", i),
                32'(RW), 32'(tv[i].erw));
            chk($sformatf("v%0d.DataW", i), DataW, tv[i].ed);
            chk($sformatf("v%0d.pending", i), pending, tv[i].ep);
            chk($sformatf("v%0d.mdu_ready", i),
                32'(mdu_ready), 32'(tv[i].er));
            chk($sformatf("v%0d.stall_req", i),
                32'(stall_req), 32'(tv[i].es));
        end

        // Fill the buffer behind wb writes, then reset mid-cycle.
        drive(1, 9, 32'h99, 1, 3, 32'h33);
        tick();
        drive(1, 9, 32'h99, 1, 4, 32'h44);
        tick();
        drive(1, 9, 32'h99, 0, 0, 0);
        chk("full.mdu_ready", 32'(mdu_ready), 32'd0);
        chk("full.pending", pending, 32'h18);
        chk("full.RegWrite", 32'(RegWrite), 32'd1);
        tick();
        tick();
        tick();
        chk("full.stall_req", 32'(stall_req), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk_idle_out("arst");
        drive(0, 0, 0, 0, 0, 0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_idle_out($sformatf("drop%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
